// File: rtl/gate_chk_pkg.sv
// Shared state encoding and reference truth tables for the gate sweep checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Truth tables are indexed by {a,b}; bit 0 is the a=0,b=0 entry.
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module gate_chk_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load takes priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives a 2-input gate through all four {a,b} combinations, waits a settle
// time per vector, and checks y against a captured truth table.
//
//   state  | meaning
//   IDLE   | waiting for start; results of the last sweep held
//   SETTLE | vector applied, counting down the settle time
//   SAMPLE | compare y against the expected entry, advance vector
//   DONE   | one-cycle done pulse, pass computed from final count
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_W = 4,
    parameter int ROUNDS   = 1,
    parameter int ERR_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          truth_table,
    input  logic [SETTLE_W-1:0] settle,
    output logic                a,
    output logic                b,
    input  logic                y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_cnt,
    output logic [3:0]          err_mask
);

    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0]    ROUND_LAST = RW'(ROUNDS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    state_t              state, state_nxt;
    logic [3:0]          tt_sh, tt_nxt;
    logic [SETTLE_W-1:0] settle_sh, settle_nxt;
    logic [1:0]          idx, idx_nxt;
    logic [RW-1:0]       round, round_nxt;
    logic [1:0]          ab_nxt;
    logic                busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0]    err_cnt_nxt;
    logic [3:0]          err_mask_nxt;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic [SETTLE_W-1:0] cnt_load_val;

    gate_chk_settle_cnt #(.W(SETTLE_W)) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // State and every output register; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tt_sh     <= '0;
            settle_sh <= '0;
            idx       <= '0;
            round     <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            err_mask  <= '0;
        end else begin
            state     <= state_nxt;
            tt_sh     <= tt_nxt;
            settle_sh <= settle_nxt;
            idx       <= idx_nxt;
            round     <= round_nxt;
            a         <= ab_nxt[1];
            b         <= ab_nxt[0];
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_cnt   <= err_cnt_nxt;
            err_mask  <= err_mask_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt    = state;
        tt_nxt       = tt_sh;
        settle_nxt   = settle_sh;
        idx_nxt      = idx;
        round_nxt    = round;
        ab_nxt       = {a, b};
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        pass_nxt     = pass;
        err_cnt_nxt  = err_cnt;
        err_mask_nxt = err_mask;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = settle_sh;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    tt_nxt       = truth_table;
                    settle_nxt   = settle;
                    err_cnt_nxt  = '0;
                    err_mask_nxt = '0;
                    pass_nxt     = 1'b0;
                    idx_nxt      = '0;
                    round_nxt    = '0;
                    ab_nxt       = 2'b00;
                    cnt_load     = 1'b1;
                    cnt_load_val = settle;
                    busy_nxt     = 1'b1;
                    state_nxt    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (y != tt_sh[idx]) begin
                    err_mask_nxt[idx] = 1'b1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt_nxt = err_cnt + ERR_W'(1);
                    end
                end
                if ((idx == 2'd3) && (round == ROUND_LAST)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 2'd1;
                    if (idx == 2'd3) begin
                        round_nxt = round + RW'(1);
                    end
                    ab_nxt    = idx + 2'd1;
                    cnt_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                pass_nxt  = (err_cnt == '0);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a table of single-round sweeps against a NOR
// gate (direct or behind a 3-stage pipeline), plus hand-written sequences for
// vector order, mid-sweep start/config changes, mid-sweep reset and
// multi-round stuck-output sweeps.
module tb_gate_sweep_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tt = TT_NOR;
    logic [3:0] settle = 4'd0;
    logic       pipe_sel = 1'b0;

    logic       a0, b0, y0, busy0, done0, pass0;
    logic [2:0] err_cnt0;
    logic [3:0] err_mask0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err_cnt1;
    logic [3:0] err_mask1;
    logic       a2, b2, busy2, done2, pass2;
    logic [1:0] err_cnt2;
    logic [3:0] err_mask2;

    logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // NOR gate under test, optionally behind three register stages.
    always @(posedge clk) begin
        p1 <= ~(a0 | b0);
        p2 <= p1;
        p3 <= p2;
    end
    assign y0 = pipe_sel ? p3 : ~(a0 | b0);

    gate_sweep_checker #(.SETTLE_W(4), .ROUNDS(1), .ERR_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .truth_table(tt), .settle(settle),
        .a(a0), .b(b0), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err_cnt0), .err_mask(err_mask0)
    );

    gate_sweep_checker #(.SETTLE_W(4), .ROUNDS(2), .ERR_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .truth_table(tt), .settle(settle),
        .a(a1), .b(b1), .y(1'b0), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err_cnt1), .err_mask(err_mask1)
    );

    gate_sweep_checker #(.SETTLE_W(4), .ROUNDS(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .truth_table(tt), .settle(settle),
        .a(a2), .b(b2), .y(1'b1), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .err_mask(err_mask2)
    );

    typedef struct {
        string      name;
        logic [3:0] tt;
        logic [3:0] settle;
        logic       pipe;
        logic       exp_pass;
        int         exp_cnt;
        logic [3:0] exp_mask;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One single-round sweep on dut0; expected latency is 4*(settle+2)+1.
    task automatic run_sweep(input vec_t v, input bit with_reset);
        int cycles;
        if (with_reset) do_reset();
        pipe_sel = v.pipe;
        tt       = v.tt;
        settle   = v.settle;
        if (!with_reset) repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({v.name, " busy after start"}, 32'(busy0), 32'd1);
        cycles = 0;
        while (!done0 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        check({v.name, " done seen"}, 32'(done0), 32'd1);
        check({v.name, " latency"}, 32'(cycles), 32'(4 * (int'(v.settle) + 2) + 1));
        check({v.name, " pass"}, 32'(pass0), 32'(v.exp_pass));
        check({v.name, " err_cnt"}, 32'(err_cnt0), 32'(v.exp_cnt));
        check({v.name, " err_mask"}, 32'(err_mask0), 32'(v.exp_mask));
        check({v.name, " ab at done"}, 32'({a0, b0}), 32'd3);
        check({v.name, " busy at done"}, 32'(busy0), 32'd1);
        @(negedge clk);
        check({v.name, " done one cycle"}, 32'(done0), 32'd0);
        check({v.name, " busy drops"}, 32'(busy0), 32'd0);
        check({v.name, " pass held"}, 32'(pass0), 32'(v.exp_pass));
    endtask

    initial begin
        int cycles, n_done, lat, lat1, lat2;
        logic [1:0] ab_exp;
        logic       pass_at;
        logic [2:0] cnt_at;
        logic [3:0] mask_at;

        vecs[0] = '{"nor",        TT_NOR,  4'd0,  1'b0, 1'b1, 0, 4'b0000};
        vecs[1] = '{"or_vs_nor",  TT_OR,   4'd0,  1'b0, 1'b0, 4, 4'b1111};
        vecs[2] = '{"pipe_s2",    TT_NOR,  4'd2,  1'b1, 1'b1, 0, 4'b0000};
        vecs[3] = '{"pipe_s1",    TT_NOR,  4'd1,  1'b1, 1'b0, 1, 4'b0010};
        vecs[4] = '{"xor_vs_nor", TT_XOR,  4'd0,  1'b0, 1'b0, 3, 4'b0111};
        vecs[5] = '{"nand_s3",    TT_NAND, 4'd3,  1'b0, 1'b0, 2, 4'b0110};
        vecs[6] = '{"and_s1",     TT_AND,  4'd1,  1'b0, 1'b0, 2, 4'b1001};
        vecs[7] = '{"nor_s15",    TT_NOR,  4'd15, 1'b0, 1'b1, 0, 4'b0000};

        // Reset state
        do_reset();
        check("rst a", 32'(a0), 32'd0);
        check("rst b", 32'(b0), 32'd0);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        check("rst pass", 32'(pass0), 32'd0);
        check("rst err_cnt", 32'(err_cnt0), 32'd0);
        check("rst err_mask", 32'(err_mask0), 32'd0);

        // Vector order 00,01,10,11 with settle=0 (one change every 2 cycles)
        tt = TT_NOR; settle = 4'd0; pipe_sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ab_exp = 2'(i);
            check($sformatf("ab order %0d", i), 32'({a0, b0}), 32'(ab_exp));
            if (i < 3) repeat (2) @(negedge clk);
        end
        cycles = 0;
        while (!done0 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check("order latency", 32'(cycles + 6), 32'd9);

        // Table of single-round sweeps
        foreach (vecs[i]) run_sweep(vecs[i], 1'b1);

        // Mid-sweep start pulse and config change must be ignored
        do_reset();
        tt = TT_NOR; settle = 4'd0; pipe_sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0; n_done = 0; lat = -1;
        pass_at = 1'b0; cnt_at = '1; mask_at = '1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start  = 1'b1;
                tt     = TT_AND;
                settle = 4'd5;
            end else begin
                start = 1'b0;
            end
            if (done0) begin
                n_done++;
                if (lat < 0) begin
                    lat = k; pass_at = pass0; cnt_at = err_cnt0; mask_at = err_mask0;
                end
            end
        end
        check("restart latency", 32'(lat), 32'd9);
        check("restart done count", 32'(n_done), 32'd1);
        check("restart pass", 32'(pass_at), 32'd1);
        check("restart err_cnt", 32'(cnt_at), 32'd0);
        check("restart err_mask", 32'(mask_at), 32'd0);

        // Reset during SETTLE of vector 2 aborts the sweep
        do_reset();
        tt = TT_OR; settle = 4'd3; pipe_sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!({a0, b0} == 2'b10) && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("abort reached vector 2", 32'({a0, b0}), 32'd2);
        @(negedge clk);
        check("abort err_cnt before reset", 32'(err_cnt0), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("abort a", 32'(a0), 32'd0);
        check("abort b", 32'(b0), 32'd0);
        check("abort busy", 32'(busy0), 32'd0);
        check("abort done", 32'(done0), 32'd0);
        check("abort err_cnt", 32'(err_cnt0), 32'd0);
        check("abort err_mask", 32'(err_mask0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        check("abort no done", 32'(n_done), 32'd0);
        run_sweep(vecs[0], 1'b0);

        // Multi-round stuck-output sweeps on dut1 (y=0) and dut2 (y=1)
        do_reset();
        tt = TT_NOR; settle = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat1 = -1; lat2 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done1 && lat1 < 0) begin
                lat1 = k;
                check("r2 err_cnt", 32'(err_cnt1), 32'd2);
                check("r2 err_mask", 32'(err_mask1), 32'b0001);
                check("r2 pass", 32'(pass1), 32'd0);
                check("r2 ab", 32'({a1, b1}), 32'd3);
                check("r2 busy", 32'(busy1), 32'd1);
            end
            if (done2 && lat2 < 0) begin
                lat2 = k;
                check("r4 err_cnt sat", 32'(err_cnt2), 32'd3);
                check("r4 err_mask", 32'(err_mask2), 32'b1110);
                check("r4 pass", 32'(pass2), 32'd0);
                check("r4 ab", 32'({a2, b2}), 32'd3);
                check("r4 busy", 32'(busy2), 32'd1);
            end
        end
        check("r2 latency", 32'(lat1), 32'd17);
        check("r4 latency", 32'(lat2), 32'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
